// File: rtl/ptmch_trg_arb.sv
// ---------------------------------------------------------------------------
// ptmch_trg_arb
//
// Purpose:
//   Merges five per-command trigger requests from the command matcher into one
//   shared trigger pulse. Each request line is edge-detected and held in a
//   pending flag. A round-robin arbiter picks one pending request at a time.
//   The winner produces a fixed-width pulse on trgOut_o, which can be followed
//   by a programmable dead time. A request that arrives while its own pending
//   flag is still set is lost, and that loss is recorded in a sticky flag.
//
// Ports:
//   clk160m_i   in   1        sole clock, rising edge
//   reset_i     in   1        synchronous active-high reset
//   trgReq_i    in   5        request lines (0 prog-exec, 1 read-status,
//                             2 block-erase, 3 page-data-read, 4 write-status)
//   arbEn_i     in   1        1 = grants allowed, 0 = capture only
//   holdOff_i   in   8        dead time after each pulse, in cycles
//   ovfClr_i    in   1        single-cycle clear of the overflow flag
//   trgOut_o    out  1        shared trigger pulse
//   trgCode_o   out  3        index of the request currently or last granted
//   trgBusy_o   out  1        high whenever the FSM is not idle
//   ovfFlag_o   out  1        sticky lost-request flag
//   evtCnt_o    out  P_CNT_W  number of grants issued (wraps)
// ---------------------------------------------------------------------------
module ptmch_trg_arb #(
    parameter int P_PLS_WIDTH = 16,
    parameter int P_CNT_W     = 16
) (
    input  logic               clk160m_i,
    input  logic               reset_i,
    input  logic [4:0]         trgReq_i,
    input  logic               arbEn_i,
    input  logic [7:0]         holdOff_i,
    input  logic               ovfClr_i,
    output logic               trgOut_o,
    output logic [2:0]         trgCode_o,
    output logic               trgBusy_o,
    output logic               ovfFlag_o,
    output logic [P_CNT_W-1:0] evtCnt_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    // Pulse counter load value: it counts down to zero, so the pulse lasts
    // P_PLS_WIDTH cycles.
    localparam logic [7:0] PLS_LAST = 8'(P_PLS_WIDTH - 1);

    state_t             state_q;
    logic               trgOut_q;
    logic               busy_q;
    logic [2:0]         code_q;
    logic [P_CNT_W-1:0] evtCnt_q;
    logic [2:0]         rrPtr_q;
    logic [7:0]         plsCnt_q;
    logic [7:0]         holdCnt_q;
    logic [7:0]         holdOff_q;

    logic [4:0]         reqPrev_q;
    logic [4:0]         arm_q;
    logic [4:0]         pend_q;
    logic [4:0]         pend_d;
    logic               ovf_q;
    logic               ovf_d;

    logic [4:0]         rise;
    logic               grantVld;
    logic [2:0]         winIdx;
    logic [4:0]         grantMask;
    logic               ovfEvt;

    // Round-robin search. The search starts one above the last granted index
    // and wraps modulo 5, so the last winner has the lowest priority.
    function automatic logic [2:0] pickWinner(input logic [4:0] pend,
                                              input logic [2:0] ptr);
        logic [2:0] idx;
        logic       found;
        int         c;
        idx   = 3'd0;
        found = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            c = (int'(ptr) + k) % 5;
            if (!found && pend[c]) begin
                idx   = 3'(c);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    // A bit counts as a new request only on a 0->1 transition. It must also
    // have been seen low at least once since reset (arm_q). Without that, a
    // line held high through reset release would look like a fresh edge.
    // A grant consumes the winner's pending flag. An edge in the same cycle
    // re-sets the flag, so that case does not count as an overflow.
    always_comb begin
        rise      = trgReq_i & ~reqPrev_q & arm_q;
        grantVld  = (state_q == S_IDLE) && arbEn_i && (|pend_q);
        winIdx    = pickWinner(pend_q, rrPtr_q);
        grantMask = grantVld ? (5'b00001 << winIdx) : 5'b00000;
        pend_d    = (pend_q & ~grantMask) | rise;
        ovfEvt    = |(rise & pend_q & ~grantMask);
        ovf_d     = ovf_q;
        if (ovfEvt) begin
            ovf_d = 1'b1;
        end else if (ovfClr_i) begin
            ovf_d = 1'b0;
        end
    end

    // Request capture. The arm mask loads from the live request lines during
    // reset. A line that is low during reset can therefore be granted straight
    // after release. A line that is high must drop first.
    always_ff @(posedge clk160m_i) begin
        if (reset_i) begin
            reqPrev_q <= 5'b00000;
            arm_q     <= ~trgReq_i;
            pend_q    <= 5'b00000;
            ovf_q     <= 1'b0;
        end else begin
            reqPrev_q <= trgReq_i;
            arm_q     <= arm_q | ~trgReq_i;
            pend_q    <= pend_d;
            ovf_q     <= ovf_d;
        end
    end

    // Arbitration FSM. All outputs are registered here and change together
    // with the state.
    // The grant cycle is spent in IDLE, so trgOut rises on the cycle after
    // the decision. The hold-off value is captured at grant time. Changing
    // the input during a pulse therefore only affects the next one.
    // arbEn is only consulted in IDLE, so dropping it never cuts a pulse or
    // a hold short.
    always_ff @(posedge clk160m_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            trgOut_q  <= 1'b0;
            busy_q    <= 1'b0;
            code_q    <= 3'd0;
            evtCnt_q  <= '0;
            rrPtr_q   <= 3'd4;
            plsCnt_q  <= 8'd0;
            holdCnt_q <= 8'd0;
            holdOff_q <= 8'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grantVld) begin
                        state_q   <= S_PULSE;
                        trgOut_q  <= 1'b1;
                        busy_q    <= 1'b1;
                        code_q    <= winIdx;
                        rrPtr_q   <= winIdx;
                        evtCnt_q  <= evtCnt_q + P_CNT_W'(1);
                        plsCnt_q  <= PLS_LAST;
                        holdOff_q <= holdOff_i;
                    end
                end
                S_PULSE: begin
                    if (plsCnt_q == 8'd0) begin
                        trgOut_q <= 1'b0;
                        if (holdOff_q == 8'd0) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q   <= S_HOLD;
                            holdCnt_q <= holdOff_q - 8'd1;
                        end
                    end else begin
                        plsCnt_q <= plsCnt_q - 8'd1;
                    end
                end
                S_HOLD: begin
                    if (holdCnt_q == 8'd0) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        holdCnt_q <= holdCnt_q - 8'd1;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    trgOut_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign trgOut_o  = trgOut_q;
    assign trgCode_o = code_q;
    assign trgBusy_o = busy_q;
    assign ovfFlag_o = ovf_q;
    assign evtCnt_o  = evtCnt_q;

endmodule

// File: tb/tb_ptmch_trg_arb.sv
// Testbench for ptmch_trg_arb. The DUT is built with a 4-bit event counter
// so that counter wrap-around is reachable in a short run.
`timescale 1ns/1ps
module tb_ptmch_trg_arb;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] trgReq;
   logic       arbEn;
   logic [7:0] holdOff;
   logic       ovfClr;
   logic       trgOut;
   logic [2:0] trgCode;
   logic       trgBusy;
   logic       ovfFlag;
   logic [3:0] evtCnt;

   int passCount  = 0;
   int checkCount = 0;

   typedef struct {
      logic [4:0] req;
      logic [7:0] hold;
      logic [7:0] holdLate;
      int         expCode;
      int         expCnt;
   } vec_t;

   vec_t vecs[5];

   always #5 clk = ~clk;

   ptmch_trg_arb #(.P_PLS_WIDTH(16), .P_CNT_W(4)) dut (
      .clk160m_i (clk),
      .reset_i   (reset),
      .trgReq_i  (trgReq),
      .arbEn_i   (arbEn),
      .holdOff_i (holdOff),
      .ovfClr_i  (ovfClr),
      .trgOut_o  (trgOut),
      .trgCode_o (trgCode),
      .trgBusy_o (trgBusy),
      .ovfFlag_o (ovfFlag),
      .evtCnt_o  (evtCnt)
   );

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive all functional inputs at once.
   task automatic applyStimulus(input logic [4:0] req, input logic en,
                                input logic [7:0] hold, input logic clr);
      trgReq  = req;
      arbEn   = en;
      holdOff = hold;
      ovfClr  = clr;
   endtask

   // Compare one observed value against its expected value.
   task automatic checkOutput(input string name, input int actual, input int expected);
      checkCount++;
      if (actual == expected) passCount++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
   endtask

   // Clock until trgOut is high. Returns the number of clocks taken, or -1
   // if trgOut did not rise within the bound.
   task automatic waitRise(output int lat);
      lat = -1;
      for (int i = 1; i <= 200; i++) begin
         tick();
         if (trgOut) begin
            lat = i;
            break;
         end
      end
   endtask

   // Called with trgOut high; returns the number of high cycles.
   task automatic measureHigh(output int w);
      w = 1;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (!trgOut) break;
         w++;
      end
   endtask

   // Called on the first low cycle; returns the number of cycles still busy.
   task automatic measureBusyLow(output int n);
      n = 0;
      for (int i = 0; i < 300; i++) begin
         if (!trgBusy) break;
         n++;
         tick();
      end
   endtask

   // Count rising edges of trgOut over a fixed window.
   task automatic countRises(input int cycles, output int n);
      logic prev;
      n    = 0;
      prev = trgOut;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (trgOut && !prev) n++;
         prev = trgOut;
      end
   endtask

   task automatic resetDut();
      applyStimulus(5'b00000, 1'b1, 8'd0, 1'b0);
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      int lat, w, n;

      vecs[0] = '{5'b00100, 8'd0,  8'd0,   2, 1};
      vecs[1] = '{5'b00001, 8'd10, 8'd3,   0, 2};
      vecs[2] = '{5'b10000, 8'd1,  8'd0,   4, 3};
      vecs[3] = '{5'b01000, 8'd5,  8'd200, 3, 4};
      vecs[4] = '{5'b00010, 8'd0,  8'd7,   1, 5};

      reset = 1'b1;
      applyStimulus(5'b00000, 1'b1, 8'd0, 1'b0);
      resetDut();
      checkOutput("reset_trgOut", trgOut, 0);
      checkOutput("reset_busy", trgBusy, 0);
      checkOutput("reset_code", trgCode, 0);
      checkOutput("reset_cnt", evtCnt, 0);
      checkOutput("reset_ovf", ovfFlag, 0);

      // Single requests from the vector table.
      foreach (vecs[v]) begin
         applyStimulus(vecs[v].req, 1'b1, vecs[v].hold, 1'b0);
         tick();
         applyStimulus(5'b00000, 1'b1, vecs[v].hold, 1'b0);
         waitRise(lat);
         checkOutput($sformatf("vec%0d_latency", v), lat + 1, 2);
         applyStimulus(5'b00000, 1'b1, vecs[v].holdLate, 1'b0);
         checkOutput($sformatf("vec%0d_code", v), trgCode, vecs[v].expCode);
         checkOutput($sformatf("vec%0d_cnt", v), evtCnt, vecs[v].expCnt);
         checkOutput($sformatf("vec%0d_busy", v), trgBusy, 1);
         measureHigh(w);
         checkOutput($sformatf("vec%0d_width", v), w, 16);
         measureBusyLow(n);
         checkOutput($sformatf("vec%0d_hold", v), n, int'(vecs[v].hold));
      end

      // Simultaneous requests: round-robin order from index 0 after reset.
      resetDut();
      applyStimulus(5'b11111, 1'b1, 8'd0, 1'b0);
      tick();
      applyStimulus(5'b00000, 1'b1, 8'd0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         waitRise(lat);
         if (k == 0) checkOutput("simul_latency", lat + 1, 2);
         else checkOutput($sformatf("simul_gap%0d", k), lat, 1);
         checkOutput($sformatf("simul_code%0d", k), trgCode, k);
         measureHigh(w);
      end
      checkOutput("simul_cnt", evtCnt, 5);
      checkOutput("simul_ovf", ovfFlag, 0);

      // Two requests with a 10-cycle hold-off.
      applyStimulus(5'b00011, 1'b1, 8'd10, 1'b0);
      tick();
      applyStimulus(5'b00000, 1'b1, 8'd10, 1'b0);
      waitRise(lat);
      checkOutput("hold_first_code", trgCode, 0);
      measureHigh(w);
      waitRise(lat);
      checkOutput("hold_gap", lat, 11);
      checkOutput("hold_second_code", trgCode, 1);
      checkOutput("hold_cnt", evtCnt, 7);
      measureHigh(w);
      measureBusyLow(n);
      checkOutput("hold_second_hold", n, 10);

      // Overflow: bit1 pulsed three times while bit0 is being served.
      resetDut();
      applyStimulus(5'b00001, 1'b1, 8'd0, 1'b0);
      tick();
      applyStimulus(5'b00000, 1'b1, 8'd0, 1'b0);
      waitRise(lat);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(5'b00010, 1'b1, 8'd0, 1'b0);
         tick();
         applyStimulus(5'b00000, 1'b1, 8'd0, 1'b0);
         tick();
      end
      checkOutput("ovf_set", ovfFlag, 1);
      measureHigh(w);
      waitRise(lat);
      checkOutput("ovf_bit1_code", trgCode, 1);
      measureHigh(w);
      countRises(40, n);
      checkOutput("ovf_extra_grants", n, 0);
      checkOutput("ovf_cnt", evtCnt, 2);
      checkOutput("ovf_sticky", ovfFlag, 1);
      applyStimulus(5'b00000, 1'b1, 8'd0, 1'b1);
      tick();
      applyStimulus(5'b00000, 1'b1, 8'd0, 1'b0);
      checkOutput("ovf_cleared", ovfFlag, 0);

      // A new overflow in the same cycle as the clear must win.
      applyStimulus(5'b00001, 1'b1, 8'd0, 1'b0);
      tick();
      applyStimulus(5'b00000, 1'b1, 8'd0, 1'b0);
      waitRise(lat);
      applyStimulus(5'b00010, 1'b1, 8'd0, 1'b0);
      tick();
      applyStimulus(5'b00000, 1'b1, 8'd0, 1'b0);
      tick();
      applyStimulus(5'b00010, 1'b1, 8'd0, 1'b1);
      tick();
      applyStimulus(5'b00000, 1'b1, 8'd0, 1'b0);
      checkOutput("ovf_clr_vs_set", ovfFlag, 1);
      measureHigh(w);
      waitRise(lat);
      measureHigh(w);
      measureBusyLow(n);

      // Gating: no grant with arbEn=0. A re-request on the grant cycle stays pending.
      resetDut();
      applyStimulus(5'b01000, 1'b0, 8'd0, 1'b0);
      tick();
      applyStimulus(5'b00000, 1'b0, 8'd0, 1'b0);
      countRises(10, n);
      checkOutput("gate_no_pulse", n, 0);
      checkOutput("gate_busy", trgBusy, 0);
      applyStimulus(5'b01000, 1'b1, 8'd0, 1'b0);
      tick();
      applyStimulus(5'b00000, 1'b0, 8'd0, 1'b0);
      checkOutput("gate_grant", trgOut, 1);
      checkOutput("gate_code", trgCode, 3);
      measureHigh(w);
      checkOutput("gate_width_en_low", w, 16);
      countRises(5, n);
      checkOutput("gate_held_pending", n, 0);
      checkOutput("gate_idle_busy", trgBusy, 0);
      applyStimulus(5'b00000, 1'b1, 8'd0, 1'b0);
      waitRise(lat);
      checkOutput("gate_regrant_lat", lat, 1);
      checkOutput("gate_regrant_code", trgCode, 3);
      checkOutput("gate_cnt", evtCnt, 2);
      checkOutput("gate_ovf", ovfFlag, 0);
      measureHigh(w);
      measureBusyLow(n);

      // Reset in the middle of a pulse with another request pending.
      applyStimulus(5'b00100, 1'b1, 8'd4, 1'b0);
      tick();
      applyStimulus(5'b00000, 1'b1, 8'd4, 1'b0);
      waitRise(lat);
      applyStimulus(5'b00010, 1'b1, 8'd4, 1'b0);
      tick();
      applyStimulus(5'b00000, 1'b1, 8'd4, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("rst_trgOut", trgOut, 0);
      checkOutput("rst_busy", trgBusy, 0);
      checkOutput("rst_code", trgCode, 0);
      checkOutput("rst_cnt", evtCnt, 0);
      checkOutput("rst_ovf", ovfFlag, 0);
      countRises(30, n);
      checkOutput("rst_pending_dropped", n, 0);

      // A line held high through reset release is not an edge.
      applyStimulus(5'b10000, 1'b1, 8'd0, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      countRises(5, n);
      checkOutput("held_no_edge", n, 0);
      checkOutput("held_busy", trgBusy, 0);
      applyStimulus(5'b00000, 1'b1, 8'd0, 1'b0);
      tick();
      applyStimulus(5'b10000, 1'b1, 8'd0, 1'b0);
      tick();
      applyStimulus(5'b00000, 1'b1, 8'd0, 1'b0);
      waitRise(lat);
      checkOutput("held_relaunch_lat", lat + 1, 2);
      checkOutput("held_relaunch_code", trgCode, 4);
      measureHigh(w);
      measureBusyLow(n);

      // Counter wrap: 15 grants bring it to all-ones, the 16th to zero.
      resetDut();
      for (int r = 0; r < 3; r++) begin
         applyStimulus(5'b11111, 1'b1, 8'd0, 1'b0);
         tick();
         applyStimulus(5'b00000, 1'b1, 8'd0, 1'b0);
         for (int k = 0; k < 5; k++) begin
            waitRise(lat);
            measureHigh(w);
         end
         measureBusyLow(n);
      end
      checkOutput("wrap_all_ones", evtCnt, 15);
      applyStimulus(5'b00001, 1'b1, 8'd0, 1'b0);
      tick();
      applyStimulus(5'b00000, 1'b1, 8'd0, 1'b0);
      waitRise(lat);
      checkOutput("wrap_zero", evtCnt, 0);
      measureHigh(w);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/ptmch_trg_arb.md
PTMCH_TRG_ARB -- requirements
Module: ptmch_trg_arb

Interface
REQ-001 Parameter P_PLS_WIDTH, default 16, SHALL set the TRG_OUT high time in CLK160M cycles (legal 1..255).
REQ-002 Parameter P_CNT_W, default 16, SHALL set the EVT_CNT width.
REQ-003 CLK160M  input  1  sole clock; all logic SHALL be on its rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 TRG_REQ  input  5  per-command trigger requests from the command matcher (bit0 program-execute, bit1 read-status, bit2 block-erase, bit3 page-data-read, bit4 write-status), synchronous to CLK160M.
REQ-006 ARB_EN  input  1  1 = grants allowed; 0 = requests captured, no new grant.
REQ-007 HOLDOFF  input  8  dead time after each pulse, in cycles.
REQ-008 OVF_CLR  input  1  single-cycle clear of OVF_FLAG.
REQ-009 TRG_OUT  output  1  shared trigger pulse.
REQ-010 TRG_CODE  output  3  index 0..4 of the request currently or last granted.
REQ-011 TRG_BUSY  output  1  high whenever the FSM is not IDLE.
REQ-012 OVF_FLAG  output  1  sticky lost-request flag.
REQ-013 EVT_CNT  output  P_CNT_W  count of grants issued.

Function
REQ-014 Each TRG_REQ bit SHALL be registered once; a rising edge (current 1, registered 0) SHALL set that bit's pending flag on the next clock.
REQ-015 A rising edge on a bit whose pending flag is already set SHALL set OVF_FLAG and SHALL leave pending set (one event kept, one lost).
REQ-016 Set and clear of the same pending flag in one cycle: set SHALL win, with no overflow.
REQ-017 The FSM SHALL have three states: IDLE, PULSE and HOLD.
REQ-018 IDLE -> PULSE when ARB_EN=1 and any pending flag is set; the winner is chosen round-robin, searching upward (mod 5) from last-granted index + 1.
REQ-019 On grant, the FSM SHALL clear the winner's pending flag, load TRG_CODE, increment EVT_CNT (wrapping from all-ones to 0) and advance the round-robin pointer to the winner.
REQ-020 TRG_OUT SHALL be high for exactly P_PLS_WIDTH consecutive cycles, starting the cycle after the grant decision; TRG_OUT SHALL be high only in PULSE.
REQ-021 Latency: with the FSM idle and ARB_EN=1, TRG_OUT SHALL rise 2 cycles after the first cycle TRG_REQ[i] is sampled high.
REQ-022 HOLDOFF SHALL be sampled on PULSE entry; on PULSE end the FSM SHALL go to HOLD for that many cycles, or straight to IDLE if the value was 0.
REQ-023 HOLD -> IDLE when the hold count expires; a pending request SHALL then be granted from IDLE on the next cycle.
REQ-024 ARB_EN falling during PULSE or HOLD SHALL NOT truncate the pulse or the hold; no grant is made while ARB_EN=0.
REQ-025 TRG_CODE SHALL hold its value until the next grant.
REQ-026 OVF_CLR SHALL clear OVF_FLAG; a new overflow in the same cycle SHALL win (flag stays 1).
REQ-027 TRG_BUSY SHALL be a registered decode of state != IDLE.

Reset
REQ-028 RESET=1 at a clock edge SHALL force: FSM to IDLE, TRG_OUT=0, TRG_BUSY=0, TRG_CODE=0, EVT_CNT=0, OVF_FLAG=0, all pending flags=0, edge registers=0, round-robin pointer=4 (first search starts at index 0).
REQ-029 RESET asserted mid-PULSE or mid-HOLD SHALL drop TRG_OUT on the next cycle and discard all pending requests.
REQ-030 A TRG_REQ bit held high through reset release SHALL NOT be seen as an edge until it goes low and then high again.

Verification
REQ-031 Single request: ARB_EN=1, HOLDOFF=0, 1-cycle TRG_REQ=5'b00100 at cycle N -> TRG_OUT high cycles N+2..N+17, TRG_CODE=2, EVT_CNT=1.
REQ-032 Simultaneous requests: TRG_REQ=5'b11111 for one cycle -> five pulses with TRG_CODE 0,1,2,3,4 in order, EVT_CNT=5, OVF_FLAG=0.
REQ-033 Hold-off: HOLDOFF=10, two requests -> 10 low cycles between the first TRG_OUT fall and the second grant cycle, plus 1 grant cycle before TRG_OUT rises again.
REQ-034 Overflow: bit1 pulsed 3 times while busy with bit0 -> one bit1 grant only, OVF_FLAG=1; OVF_CLR -> 0.
REQ-035 Gating and reset: ARB_EN=0 with request bit3 -> no pulse, TRG_BUSY=0; ARB_EN=1 -> grant; RESET mid-PULSE -> TRG_OUT=0 next cycle, all outputs at reset values.
REQ-036 Wrap: preload EVT_CNT to all-ones via 2^P_CNT_W - 1 grants (or a P_CNT_W=4 build) -> next grant gives EVT_CNT=0.
